// File: rtl/ring_pkg.sv
// Shared definitions for the WS2812B ring frame sequencer: pixel width,
// default GRB colours and the frame controller state encoding.
package ring_pkg;

    localparam int GRB_W = 24;

    localparam logic [GRB_W-1:0] COLOUR_ON_DEF  = 24'h00_40_00;
    localparam logic [GRB_W-1:0] COLOUR_OFF_DEF = 24'h00_00_04;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SEND  = 2'd1;
    localparam state_t ST_LATCH = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ring_latch_timer.sv
// Latch gap timer: counts CYCLES clocks after start and flags the final one,
// which is where the ring has seen a long enough low period to latch.
module ring_latch_timer #(
    parameter int CYCLES = 3000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] count;
    logic             active;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            active <= 1'b0;
        end else if (start) begin
            count  <= '0;
            active <= 1'b1;
        end else if (active) begin
            if (count == LAST) begin
                active <= 1'b0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign done = active && (count == LAST);

endmodule

// File: rtl/ring_frame_sequencer.sv
// Frame controller for the WS2812B ring: streams one GRB word per LED over
// valid/ready, then holds the latch gap, and redraws whenever content changes.
module ring_frame_sequencer
    import ring_pkg::*;
#(
    parameter int NUM_LEDS     = 12,
    parameter int POS_W        = 4,
    parameter int RESET_CYCLES = 3000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [POS_W-1:0] position,
    input  logic             mode,
    input  logic [GRB_W-1:0] colour_on,
    input  logic [GRB_W-1:0] colour_off,
    input  logic             refresh_req,
    output logic [GRB_W-1:0] pix_data,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             busy,
    output logic             frame_done
);

    localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int CMP_W = max_int(POS_W, IDX_W);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
    localparam logic [CMP_W-1:0] LAST_LED = CMP_W'(NUM_LEDS - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             pending;
    logic [POS_W-1:0] pos_snap;
    logic             mode_snap;
    logic [POS_W-1:0] last_pos;
    logic             last_mode;
    logic [GRB_W-1:0] on_snap;
    logic [GRB_W-1:0] off_snap;

    logic [POS_W-1:0] pos_clamped;
    logic             lit;
    logic             change;
    logic             timer_start;
    logic             timer_done;

    assign pos_clamped = (CMP_W'(position) > LAST_LED) ? POS_W'(NUM_LEDS - 1) : position;

    // Lit test uses only the frame snapshot so the word never tears mid-frame.
    assign lit = mode_snap ? (CMP_W'(idx) <= CMP_W'(pos_snap))
                           : (CMP_W'(idx) == CMP_W'(pos_snap));

    assign pix_data    = pix_valid ? (lit ? on_snap : off_snap) : '0;
    assign change      = (position != last_pos) || (mode != last_mode) || refresh_req;
    assign timer_start = (state == ST_SEND) && pix_ready && (idx == LAST_IDX);
    assign busy        = (state != ST_IDLE);
    assign frame_done  = (state == ST_LATCH) && timer_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            pix_valid <= 1'b0;
            pending   <= 1'b1;
            pos_snap  <= '0;
            mode_snap <= 1'b0;
            last_pos  <= '0;
            last_mode <= 1'b0;
            on_snap   <= '0;
            off_snap  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pending) begin
                        pos_snap  <= pos_clamped;
                        mode_snap <= mode;
                        on_snap   <= colour_on;
                        off_snap  <= colour_off;
                        pending   <= 1'b0;
                        idx       <= '0;
                        pix_valid <= 1'b1;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (pix_ready) begin
                        if (idx == LAST_IDX) begin
                            pix_valid <= 1'b0;
                            state     <= ST_LATCH;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_LATCH: begin
                    if (timer_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    pix_valid <= 1'b0;
                end
            endcase

            // Placed after the IDLE clear so a same-cycle change still queues a frame.
            if (change) begin
                pending   <= 1'b1;
                last_pos  <= position;
                last_mode <= mode;
            end
        end
    end

    ring_latch_timer #(
        .CYCLES(RESET_CYCLES)
    ) u_latch_timer (
        .clk  (clk),
        .rst  (rst),
        .start(timer_start),
        .done (timer_done)
    );

endmodule

// File: tb/tb_ring_frame_sequencer.sv
// Self-checking bench for ring_frame_sequencer: a pixel-level model checks every
// transfer, stall and latch gap, and directed tests pin frame contents and counts.
module tb_ring_frame_sequencer;
    import ring_pkg::*;

    localparam int NUM_LEDS     = 12;
    localparam int POS_W        = 4;
    localparam int RESET_CYCLES = 3000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [POS_W-1:0] position = '0;
    logic             mode = 1'b0;
    logic [GRB_W-1:0] colour_on = COLOUR_ON_DEF;
    logic [GRB_W-1:0] colour_off = COLOUR_OFF_DEF;
    logic             refresh_req = 1'b0;
    logic [GRB_W-1:0] pix_data;
    logic             pix_valid;
    logic             pix_ready = 1'b1;
    logic             busy;
    logic             frame_done;

    ring_frame_sequencer #(
        .NUM_LEDS(NUM_LEDS),
        .POS_W(POS_W),
        .RESET_CYCLES(RESET_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .position(position),
        .mode(mode),
        .colour_on(colour_on),
        .colour_off(colour_off),
        .refresh_req(refresh_req),
        .pix_data(pix_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    endtask

    // Reference rule: which word LED i must carry for a given frame snapshot.
    function automatic logic [GRB_W-1:0] model_word(input int i, input int p, input logic md,
                                                    input logic [GRB_W-1:0] on, input logic [GRB_W-1:0] off);
        int  pc;
        bit  is_lit;
        pc = (p > NUM_LEDS - 1) ? NUM_LEDS - 1 : p;
        is_lit = md ? (i <= pc) : (i == pc);
        return is_lit ? on : off;
    endfunction

    // Monitor state: phase 0 = idle, 1 = sending, 2 = latch gap.
    int                  phase = 0;
    int                  words = 0;
    int                  low_cnt = 0;
    int                  last_gap = 0;
    int                  frames_done = 0;
    bit                  have_gap = 0;
    bit                  stall_prev = 0;
    logic [GRB_W-1:0]    held = '0;
    logic [NUM_LEDS-1:0] mask = '0;
    logic [NUM_LEDS-1:0] mask_log[$];
    int                  m_pos = 0;
    logic                m_mode = 1'b0;
    logic [GRB_W-1:0]    m_on = '0;
    logic [GRB_W-1:0]    m_off = '0;
    int                  prev_pos = 0;
    logic                prev_mode = 1'b0;
    logic [GRB_W-1:0]    prev_on = '0;
    logic [GRB_W-1:0]    prev_off = '0;

    always @(negedge clk) begin
        if (rst) begin
            phase      = 0;
            words      = 0;
            low_cnt    = 0;
            have_gap   = 0;
            stall_prev = 0;
        end else if (phase == 2) begin
            low_cnt++;
            checkOutput("valid_latch", {31'd0, pix_valid}, 32'd0);
            checkOutput("busy_latch", {31'd0, busy}, 32'd1);
            if (frame_done) begin
                checkOutput("latch_len", low_cnt, RESET_CYCLES);
                frames_done++;
                mask_log.push_back(mask);
                phase    = 0;
                have_gap = 1;
            end else if (low_cnt > RESET_CYCLES) begin
                checkOutput("frame_done_missing", 32'd0, 32'd1);
                phase = 0;
            end
        end else begin
            if (phase == 0 && pix_valid) begin
                if (have_gap) last_gap = low_cnt;
                m_pos      = prev_pos;
                m_mode     = prev_mode;
                m_on       = prev_on;
                m_off      = prev_off;
                phase      = 1;
                words      = 0;
                mask       = '0;
                stall_prev = 0;
            end
            if (phase == 0) begin
                low_cnt++;
                checkOutput("busy_idle", {31'd0, busy}, 32'd0);
                checkOutput("frame_done_idle", {31'd0, frame_done}, 32'd0);
            end else begin
                checkOutput("valid_send", {31'd0, pix_valid}, 32'd1);
                checkOutput("busy_send", {31'd0, busy}, 32'd1);
                checkOutput("frame_done_send", {31'd0, frame_done}, 32'd0);
                if (stall_prev) checkOutput("stall_stable", {8'd0, pix_data}, {8'd0, held});
                if (pix_valid && pix_ready) begin
                    checkOutput($sformatf("word%0d", words), {8'd0, pix_data},
                                {8'd0, model_word(words, m_pos, m_mode, m_on, m_off)});
                    if (pix_data === m_on) mask[words] = 1'b1;
                    words++;
                    if (words == NUM_LEDS) begin
                        phase   = 2;
                        low_cnt = 0;
                    end
                end
                stall_prev = pix_valid && !pix_ready;
                held       = pix_data;
            end
        end
        prev_pos  = int'(position);
        prev_mode = mode;
        prev_on   = colour_on;
        prev_off  = colour_off;
    end

    // Backpressure source: repeating 1,0,0,1 ready pattern while enabled.
    bit         bp_en = 0;
    int         bp_i = 0;
    logic [3:0] bp_pat = 4'b1001;

    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            pix_ready = bp_pat[bp_i % 4];
            bp_i++;
        end
    end

    task automatic applyStimulus(input logic [POS_W-1:0] p, input logic m, input logic refresh);
        @(posedge clk);
        #1;
        position    = p;
        mode        = m;
        refresh_req = refresh;
        if (refresh) begin
            @(posedge clk);
            #1;
            refresh_req = 1'b0;
        end
    endtask

    task automatic waitQuiet(input string tag);
        int quiet;
        bit ok;
        quiet = 0;
        ok    = 0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            #2;
            if (!busy && !pix_valid) quiet++;
            else quiet = 0;
            if (quiet >= 4) begin
                ok = 1;
                break;
            end
        end
        if (!ok) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic waitWords(input int n, input string tag);
        bit ok;
        ok = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            #2;
            if (phase == 1 && words >= n) begin
                ok = 1;
                break;
            end
        end
        if (!ok) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] mask_back(input int k);
        if (mask_log.size() < k) return 32'hFFFF_FFFF;
        return {20'd0, mask_log[mask_log.size() - k]};
    endfunction

    initial begin : watchdog
        #900000;
        n_checks++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : stimulus
        int f0;

        // Reset state, then the post-reset frame plus the one queued by the position change.
        rst      = 1'b1;
        position = 4'd3;
        mode     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", {31'd0, pix_valid}, 32'd0);
        checkOutput("rst_data", {8'd0, pix_data}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_frame_done", {31'd0, frame_done}, 32'd0);
        f0 = frames_done;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("release_valid_low", {31'd0, pix_valid}, 32'd0);
        @(negedge clk);
        checkOutput("release_valid_high", {31'd0, pix_valid}, 32'd1);
        waitQuiet("t1");
        checkOutput("t1_frames", frames_done - f0, 32'd2);
        checkOutput("t1_mask_a", mask_back(2), 32'h008);
        checkOutput("t1_mask_b", mask_back(1), 32'h008);
        checkOutput("t1_gap", last_gap, RESET_CYCLES + 1);

        // Bar mode with a new on-colour.
        colour_on = 24'h12_34_56;
        f0 = frames_done;
        applyStimulus(4'd5, 1'b1, 1'b0);
        waitQuiet("t2");
        checkOutput("t2_frames", frames_done - f0, 32'd1);
        checkOutput("t2_mask", mask_back(1), 32'h03F);

        // Backpressure on a refresh of the same bar.
        f0 = frames_done;
        bp_en = 1;
        applyStimulus(4'd5, 1'b1, 1'b1);
        waitQuiet("t3");
        bp_en = 0;
        @(posedge clk);
        #1 pix_ready = 1'b1;
        checkOutput("t3_frames", frames_done - f0, 32'd1);
        checkOutput("t3_mask", mask_back(1), 32'h03F);

        // Mid-frame changes: current frame keeps LED 3, exactly one extra frame shows LED 7.
        applyStimulus(4'd3, 1'b0, 1'b0);
        waitQuiet("t4a");
        checkOutput("t4_setup_mask", mask_back(1), 32'h008);
        f0 = frames_done;
        applyStimulus(4'd3, 1'b0, 1'b1);
        waitWords(4, "t4_w4");
        @(posedge clk);
        #1;
        position  = 4'd7;
        colour_on = 24'hFF_00_00;
        waitWords(8, "t4_w8");
        applyStimulus(4'd7, 1'b0, 1'b1);
        waitQuiet("t4b");
        checkOutput("t4_frames", frames_done - f0, 32'd2);
        checkOutput("t4_mask_old", mask_back(2), 32'h008);
        checkOutput("t4_mask_new", mask_back(1), 32'h080);

        // Out-of-range position clamps to the last LED.
        applyStimulus(4'd13, 1'b0, 1'b0);
        waitQuiet("t5a");
        checkOutput("t5_clamp_mask", mask_back(1), 32'h800);

        // Refresh from IDLE: valid appears two edges after the request is driven.
        f0 = frames_done;
        @(posedge clk);
        #1 refresh_req = 1'b1;
        @(negedge clk);
        checkOutput("refresh_lat0", {31'd0, pix_valid}, 32'd0);
        @(posedge clk);
        #1 refresh_req = 1'b0;
        @(negedge clk);
        checkOutput("refresh_lat1", {31'd0, pix_valid}, 32'd0);
        @(negedge clk);
        checkOutput("refresh_lat2", {31'd0, pix_valid}, 32'd1);
        waitQuiet("t5b");
        checkOutput("t5_frames", frames_done - f0, 32'd1);
        checkOutput("t5_refresh_mask", mask_back(1), 32'h800);

        // Reset mid-frame aborts, then a full frame restarts from LED 0.
        applyStimulus(4'd13, 1'b0, 1'b1);
        waitWords(6, "t6_w6");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("abort_valid", {31'd0, pix_valid}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_frame_done", {31'd0, frame_done}, 32'd0);
        checkOutput("abort_data", {8'd0, pix_data}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        f0 = frames_done;
        waitQuiet("t6");
        checkOutput("t6_frames", frames_done - f0, 32'd2);
        checkOutput("t6_mask", mask_back(1), 32'h800);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
